fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Fetch stage that produces the instruction word and next-instruction address consumed by the F/D pipeline latch.
- Owns the PC, drives the synchronous instruction memory (1-cycle read latency), and tracks the in-flight fetch.
- Applies stalls from hazard detection and redirects from branch/jump resolution.
- Generates the F/D latch enable and clear.

Parameters:
- IADDR_W, 12, instruction address width (PC width).
- INSN_W, 32, instruction word width.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous and active-high.
- stall  in  1  hold fetch and F/D contents (load-use or multdiv hazard).
- redirect  in  1  taken branch/jump resolved; fetch must restart at redirect_addr.
- redirect_addr  in  IADDR_W  target address of the redirect.
- q_imem  in  INSN_W  instruction memory read data; valid one cycle after address_imem.
- address_imem  out  IADDR_W  instruction memory read address (combinational).
- q_imem_f  out  INSN_W  instruction to the F/D latch; 0 (nop) when not valid.
- next_iaddr_f  out  IADDR_W  address of the returned instruction + 1, to the F/D latch.
- fd_ena  out  1  F/D latch enable.
- fd_clr  out  1  F/D latch flush.
- insn_count  out  CNT_W  number of instructions handed to decode.

Behaviour:
- State registers:
  - pc: next address to issue.
  - pc_d: address whose data is on q_imem this cycle.
  - valid_d: q_imem holds a correct-path instruction.
  - insn_count.
- On a clock edge with clr=1: pc=0, pc_d=0, valid_d=0, insn_count=0. clr overrides redirect and stall.
- Output while valid_d=0: q_imem_f=0; next_iaddr_f=pc_d+1; fd_clr=0; fd_ena=1 unless stalled.
- Priority is redirect > stall > normal.
- Normal (redirect=0, stall=0):
  - address_imem=pc.
  - Edge: pc_d<=pc, pc<=pc+1, valid_d<=1.
- Stall (redirect=0, stall=1):
  - address_imem=pc_d, so the same word is re-read.
  - Edge: pc, pc_d, valid_d hold.
  - fd_ena=0.
- Redirect (redirect=1, stall ignored):
  - address_imem=redirect_addr (zero-cycle target issue).
  - Edge: pc_d<=redirect_addr, pc<=redirect_addr+1, valid_d<=1.
  - Same cycle: fd_clr=1, fd_ena=1, q_imem_f=0, squashing the wrong-path word currently returning.
  - Redirect penalty: exactly one bubble; target instruction appears on q_imem_f the next cycle.
- Combinational outputs:
  - q_imem_f = (valid_d & ~redirect) ? q_imem : 0.
  - next_iaddr_f = pc_d+1 modulo 2^IADDR_W.
  - fd_ena = ~stall | redirect.
  - fd_clr = redirect.
- Wrap-around:
  - pc+1 and pc_d+1 wrap 0xFFF -> 0x000 with no flag.
  - Redirect to 0xFFF gives pc=0x000.
- insn_count:
  - Increments on an edge when fd_ena & valid_d & ~redirect & ~clr.
  - Wraps at 2^CNT_W.
- Back-to-back redirects: each one independently issues its target; the last one wins.
- Redirect arriving the cycle after reset: allowed; it squashes nothing visible (valid_d already 0) and issues the target.
- No combinational path from q_imem to any control output.

Test Plan:
- Reset then free-run: clr=1 for 2 cycles, then 0; imem[n]=0x1000_0000+n.
  - First cycle after reset: q_imem_f=0.
  - Then q_imem_f=0x1000_0000 with next_iaddr_f=1, then 0x1000_0001 with next_iaddr_f=2.
  - insn_count=3 after 4 cycles.
- Stall: assert stall for 3 cycles while pc_d=5.
  - address_imem=5, fd_ena=0, q_imem_f=imem[5] held, insn_count frozen.
  - On release: imem[6] follows on the next cycle, with no duplicate and no skip.
- Redirect: redirect=1, redirect_addr=0x040 while pc_d=0x010.
  - That cycle: fd_clr=1, q_imem_f=0, address_imem=0x040.
  - Next cycle: q_imem_f=imem[0x040], next_iaddr_f=0x041.
- Redirect with stall: redirect=1 and stall=1 in the same cycle, redirect_addr=0x100.
  - fd_ena=1, fd_clr=1; next cycle q_imem_f=imem[0x100].
- Wrap: redirect_addr=0xFFE, then run 3 cycles.
  - pc_d sequence 0xFFE, 0xFFF, 0x000; next_iaddr_f for 0xFFF equals 0x000.
- Reset mid-operation: clr=1 during a redirect to 0x200.
  - pc=0, valid_d=0, insn_count=0; next address_imem=0, not 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads and hands instructions to the F/D latch.
// Latency: 1 cycle from address_imem to q_imem_f; a redirect costs exactly one bubble.
// Backpressure: stall re-reads the returning word and holds the F/D latch; redirect overrides stall.
module fetch_unit #(
    parameter int IADDR_W = 12,
    parameter int INSN_W  = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               clr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [IADDR_W-1:0] redirect_addr,
    input  logic [INSN_W-1:0]  q_imem,
    output logic [IADDR_W-1:0] address_imem,
    output logic [INSN_W-1:0]  q_imem_f,
    output logic [IADDR_W-1:0] next_iaddr_f,
    output logic               fd_ena,
    output logic               fd_clr,
    output logic [CNT_W-1:0]   insn_count
);

    // pc: next address to issue; pc_d: address whose data is on q_imem now
    logic [IADDR_W-1:0] pc;
    logic [IADDR_W-1:0] pc_d;
    logic               valid_d;
    logic               hand_off;

    // Redirect issues its target in the same cycle; a stall re-reads the word
    // already returning so the held F/D contents stay consistent with q_imem.
    always_comb begin
        address_imem = pc;
        if (redirect) begin
            address_imem = redirect_addr;
        end else if (stall) begin
            address_imem = pc_d;
        end
    end

    // Control outputs depend only on registered state and the hazard inputs,
    // never on q_imem, so the memory data path stays off the control path.
    assign fd_ena       = ~stall | redirect;
    assign fd_clr       = redirect;
    assign q_imem_f     = (valid_d & ~redirect) ? q_imem : '0;
    assign next_iaddr_f = pc_d + IADDR_W'(1);
    assign hand_off     = fd_ena & valid_d & ~redirect;

    // PC / in-flight tracking and the handed-to-decode counter; clr wins over all.
    always_ff @(posedge clock) begin
        if (clr) begin
            pc         <= '0;
            pc_d       <= '0;
            valid_d    <= 1'b0;
            insn_count <= '0;
        end else begin
            if (redirect) begin
                pc_d    <= redirect_addr;
                pc      <= redirect_addr + IADDR_W'(1);
                valid_d <= 1'b1;
            end else if (!stall) begin
                pc_d    <= pc;
                pc      <= pc + IADDR_W'(1);
                valid_d <= 1'b1;
            end
            if (hand_off) begin
                insn_count <= insn_count + CNT_W'(1);
            end
        end
    end

endmodule
